// File: rtl/eco_patch_unit.sv
// eco_patch_unit
// Programmable ECO patch stage. Up to NP product terms over the operand
// vector v = {a, b} are evaluated against an active configuration bank; the
// OR of the target masks of all firing terms is XORed onto base_y. Terms are
// staged in a shadow bank and copied to the active bank atomically on commit.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, a, b      operand vector and its valid
//   base_y              unpatched function output
//   out_valid, y        patched output, fixed latency 2
//   cfg_valid/cfg_idx/cfg_care/cfg_match/cfg_target/cfg_en
//                       shadow-entry write
//   cfg_commit          copy shadow bank into active bank
//   cfg_ready           low for the one cycle after an accepted commit
//   hit, hit_clr        sticky per-entry fire flags and their clear
module eco_patch_unit #(
  parameter int W  = 4,
  parameter int OW = 4,
  parameter int NP = 4,
  localparam int IW = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [OW-1:0]   base_y,
  output logic            out_valid,
  output logic [OW-1:0]   y,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [IW-1:0]   cfg_idx,
  input  logic [2*W-1:0]  cfg_care,
  input  logic [2*W-1:0]  cfg_match,
  input  logic [OW-1:0]   cfg_target,
  input  logic            cfg_en,
  input  logic            cfg_commit,
  output logic [NP-1:0]   hit,
  input  logic            hit_clr
);

  // configuration banks
  logic [NP-1:0]                sh_en_q,    sh_en_d;
  logic [NP-1:0][2*W-1:0]       sh_care_q,  sh_care_d;
  logic [NP-1:0][2*W-1:0]       sh_match_q, sh_match_d;
  logic [NP-1:0][OW-1:0]        sh_tgt_q,   sh_tgt_d;
  logic [NP-1:0]                ac_en_q,    ac_en_d;
  logic [NP-1:0][2*W-1:0]       ac_care_q,  ac_care_d;
  logic [NP-1:0][2*W-1:0]       ac_match_q, ac_match_d;
  logic [NP-1:0][OW-1:0]        ac_tgt_q,   ac_tgt_d;
  logic                         cfg_ready_q, cfg_ready_d;

  // pipeline
  logic                         s1_valid_q;
  logic [OW-1:0]                s1_base_q;
  logic [NP-1:0]                s1_fire_q;
  logic [OW-1:0]                s1_mask_q;
  logic                         s2_valid_q;
  logic [OW-1:0]                s2_y_q, s2_y_d;
  logic [NP-1:0]                hit_q, hit_d;

  logic [2*W-1:0]               v;
  logic [NP-1:0]                fire_d;
  logic [OW-1:0]                mask_d;
  logic                         idx_ok;
  logic                         wr_acc;
  logic                         commit_acc;

  assign v          = {a, b};
  assign idx_ok     = (32'(cfg_idx) < 32'(NP));
  assign wr_acc     = cfg_valid && cfg_ready_q && idx_ok;
  assign commit_acc = cfg_commit && cfg_ready_q;

  // Term evaluation against the active bank as it stands this cycle.
  // The target mask is resolved here too, so a commit landing while a
  // vector sits in stage 1 cannot retarget that vector.
  always_comb begin
    fire_d = '0;
    mask_d = '0;
    for (int i = 0; i < NP; i++) begin
      fire_d[i] = ac_en_q[i] && (((v ^ ac_match_q[i]) & ac_care_q[i]) == '0);
      if (fire_d[i]) begin
        mask_d = mask_d | ac_tgt_q[i];
      end
    end
  end

  // Shadow write first; the commit copies the post-write shadow so a
  // same-cycle write is included in the committed bank.
  always_comb begin
    sh_en_d    = sh_en_q;
    sh_care_d  = sh_care_q;
    sh_match_d = sh_match_q;
    sh_tgt_d   = sh_tgt_q;
    if (wr_acc) begin
      sh_en_d[cfg_idx]    = cfg_en;
      sh_care_d[cfg_idx]  = cfg_care;
      sh_match_d[cfg_idx] = cfg_match;
      sh_tgt_d[cfg_idx]   = cfg_target;
    end
  end

  always_comb begin
    ac_en_d    = ac_en_q;
    ac_care_d  = ac_care_q;
    ac_match_d = ac_match_q;
    ac_tgt_d   = ac_tgt_q;
    if (commit_acc) begin
      ac_en_d    = sh_en_d;
      ac_care_d  = sh_care_d;
      ac_match_d = sh_match_d;
      ac_tgt_d   = sh_tgt_d;
    end
  end

  // One-cycle stall after every accepted commit.
  assign cfg_ready_d = !commit_acc;

  // A new fire overrides a same-cycle clear.
  assign hit_d = (hit_clr ? '0 : hit_q) | (in_valid ? fire_d : '0);

  // y holds its last value through bubbles.
  assign s2_y_d = s1_valid_q ? (s1_base_q ^ s1_mask_q) : s2_y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_en_q     <= '0;
      sh_care_q   <= '0;
      sh_match_q  <= '0;
      sh_tgt_q    <= '0;
      ac_en_q     <= '0;
      ac_care_q   <= '0;
      ac_match_q  <= '0;
      ac_tgt_q    <= '0;
      cfg_ready_q <= 1'b1;
      s1_valid_q  <= 1'b0;
      s1_base_q   <= '0;
      s1_fire_q   <= '0;
      s1_mask_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_y_q      <= '0;
      hit_q       <= '0;
    end else begin
      sh_en_q     <= sh_en_d;
      sh_care_q   <= sh_care_d;
      sh_match_q  <= sh_match_d;
      sh_tgt_q    <= sh_tgt_d;
      ac_en_q     <= ac_en_d;
      ac_care_q   <= ac_care_d;
      ac_match_q  <= ac_match_d;
      ac_tgt_q    <= ac_tgt_d;
      cfg_ready_q <= cfg_ready_d;
      s1_valid_q  <= in_valid;
      s1_base_q   <= base_y;
      s1_fire_q   <= fire_d;
      s1_mask_q   <= mask_d;
      s2_valid_q  <= s1_valid_q;
      s2_y_q      <= s2_y_d;
      hit_q       <= hit_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign y         = s2_y_q;
  assign cfg_ready = cfg_ready_q;
  assign hit       = hit_q;

  // Fire bits are carried for observability alongside the resolved mask.
  logic unused_fire;
  assign unused_fire = ^s1_fire_q;

endmodule

// File: tb/tb_eco_patch_unit.sv
module tb_eco_patch_unit;
  localparam int W  = 4;
  localparam int OW = 4;
  localparam int NP = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  a, b;
  logic [OW-1:0] base_y;
  logic          out_valid;
  logic [OW-1:0] y;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [IW-1:0] cfg_idx;
  logic [2*W-1:0] cfg_care, cfg_match;
  logic [OW-1:0] cfg_target;
  logic          cfg_en;
  logic          cfg_commit;
  logic [NP-1:0] hit;
  logic          hit_clr;

  int errors = 0;
  int checks = 0;

  eco_patch_unit #(.W(W), .OW(OW), .NP(NP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .base_y(base_y),
    .out_valid(out_valid), .y(y), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idx(cfg_idx), .cfg_care(cfg_care), .cfg_match(cfg_match),
    .cfg_target(cfg_target), .cfg_en(cfg_en), .cfg_commit(cfg_commit),
    .hit(hit), .hit_clr(hit_clr)
  );

  always #5 clk = ~clk;

  // reference model state
  logic           ms_en[NP], ma_en[NP];
  logic [2*W-1:0] ms_care[NP], ma_care[NP], ms_match[NP], ma_match[NP];
  logic [OW-1:0]  ms_tgt[NP], ma_tgt[NP];
  logic           m_ready;
  logic           m_p1v, m_ov;
  logic [OW-1:0]  m_p1y, m_y;
  logic [NP-1:0]  m_hit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Term i matches when every cared bit of v equals the corresponding match bit.
  function automatic logic term_hits(input int i, input logic [2*W-1:0] vv);
    if (!ma_en[i]) return 1'b0;
    for (int k = 0; k < 2*W; k++)
      if (ma_care[i][k] && (vv[k] != ma_match[i][k])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic [NP-1:0] fired;
    logic [OW-1:0] pm;
    logic wr, cm;
    if (rst) begin
      for (int i = 0; i < NP; i++) begin
        ms_en[i] = 0; ms_care[i] = 0; ms_match[i] = 0; ms_tgt[i] = 0;
        ma_en[i] = 0; ma_care[i] = 0; ma_match[i] = 0; ma_tgt[i] = 0;
      end
      m_ready = 1; m_p1v = 0; m_ov = 0; m_p1y = 0; m_y = 0; m_hit = 0;
      return;
    end
    fired = '0;
    pm = '0;
    for (int i = 0; i < NP; i++) begin
      fired[i] = term_hits(i, {a, b});
      if (fired[i]) pm = pm | ma_tgt[i];
    end
    m_ov = m_p1v;
    if (m_p1v) m_y = m_p1y;
    m_p1v = in_valid;
    m_p1y = base_y ^ pm;
    m_hit = (hit_clr ? '0 : m_hit) | (in_valid ? fired : '0);
    wr = cfg_valid && m_ready && (int'(cfg_idx) < NP);
    cm = cfg_commit && m_ready;
    if (wr) begin
      ms_en[cfg_idx] = cfg_en; ms_care[cfg_idx] = cfg_care;
      ms_match[cfg_idx] = cfg_match; ms_tgt[cfg_idx] = cfg_target;
    end
    if (cm) begin
      ma_en = ms_en; ma_care = ms_care; ma_match = ms_match; ma_tgt = ms_tgt;
    end
    m_ready = !cm;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("y", 32'(y), 32'(m_y));
    chk("hit", 32'(hit), 32'(m_hit));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
  endtask

  task automatic cfg_wr(input int idx, input logic [7:0] care, input logic [7:0] match,
                        input logic [3:0] tgt, input logic en);
    cfg_valid = 1; cfg_idx = IW'(idx); cfg_care = care; cfg_match = match;
    cfg_target = tgt; cfg_en = en;
    step();
    cfg_valid = 0;
  endtask

  task automatic commit();
    cfg_commit = 1;
    step();
    cfg_commit = 0;
    step();
  endtask

  task automatic vec(input logic [3:0] va, input logic [3:0] vb, input logic [3:0] vy);
    in_valid = 1; a = va; b = vb; base_y = vy;
    step();
    in_valid = 0;
    step();
  endtask

  initial begin
    rst = 1; in_valid = 0; a = 0; b = 0; base_y = 0;
    cfg_valid = 0; cfg_idx = 0; cfg_care = 0; cfg_match = 0; cfg_target = 0;
    cfg_en = 0; cfg_commit = 0; hit_clr = 0;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    rst = 0;

    // unconfigured pass-through
    vec(4'h8, 4'h1, 4'h5);
    chk("pass_valid", 32'(out_valid), 1);
    chk("pass_y", 32'(y), 32'h5);
    chk("pass_hit", 32'(hit), 0);

    // original fix replayed
    cfg_wr(0, 8'h83, 8'h81, 4'b0010, 1);
    commit();
    vec(4'b1000, 4'b0001, 4'h0);
    chk("fix_y", 32'(y), 32'h2);
    chk("fix_hit", 32'(hit), 32'h1);
    vec(4'b1000, 4'b0011, 4'h0);
    chk("fix_miss_y", 32'(y), 32'h0);
    chk("fix_miss_hit", 32'(hit), 32'h1);

    // shadow isolation
    cfg_wr(1, 8'h00, 8'h00, 4'h8, 1);
    cfg_wr(0, 8'h00, 8'h00, 4'h0, 0);
    in_valid = 1; base_y = 4'h3;
    for (int i = 0; i < 10; i++) begin
      a = 4'($urandom_range(0, 7)); b = 4'($urandom);
      step();
    end
    step();
    chk("shadow_y", 32'(y), 32'h3);
    cfg_commit = 1;
    step();
    cfg_commit = 0;
    for (int i = 0; i < 3; i++) begin
      a = 4'($urandom); b = 4'($urandom);
      step();
    end
    in_valid = 0;
    chk("commit_y", 32'(y), 32'hB);
    step(); step();

    // commit stall with same-cycle write; write during stall dropped
    cfg_valid = 1; cfg_idx = 3; cfg_care = 0; cfg_match = 0; cfg_target = 4'h4; cfg_en = 1;
    cfg_commit = 1;
    step();
    chk("stall_ready", 32'(cfg_ready), 0);
    cfg_commit = 0; cfg_idx = 2; cfg_target = 4'h1;
    step();
    cfg_valid = 0;
    vec(4'($urandom), 4'($urandom), 4'h0);
    chk("stall_y", 32'(y), 32'hC);
    commit();
    vec(4'($urandom), 4'($urandom), 4'h0);
    chk("dropped_y", 32'(y), 32'hC);

    // overlapping targets do not cancel; hit clear priority
    cfg_wr(0, 8'h00, 8'h00, 4'h1, 1);
    cfg_wr(1, 8'h00, 8'h00, 4'h1, 1);
    cfg_wr(3, 8'h00, 8'h00, 4'h0, 0);
    commit();
    vec(4'($urandom), 4'($urandom), 4'h0);
    chk("overlap_y", 32'(y), 32'h1);
    hit_clr = 1;
    step();
    chk("clr_hit", 32'(hit), 0);
    in_valid = 1;
    step();
    in_valid = 0;
    chk("set_wins", 32'(hit), 32'h3);
    step();
    chk("clr_again", 32'(hit), 0);
    hit_clr = 0;

    // mid-stream reset
    in_valid = 1; base_y = 4'h6; a = 4'($urandom); b = 4'($urandom);
    step();
    rst = 1;
    step();
    chk("mrst_v1", 32'(out_valid), 0);
    rst = 0;
    step();
    chk("mrst_v2", 32'(out_valid), 0);
    step();
    in_valid = 0;
    chk("mrst_v3", 32'(out_valid), 1);
    chk("mrst_y", 32'(y), 32'h6);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom % 97) == 0;
      in_valid   = ($urandom % 4) != 0;
      a          = 4'($urandom);
      b          = 4'($urandom);
      base_y     = 4'($urandom);
      cfg_valid  = ($urandom % 4) == 0;
      cfg_idx    = IW'($urandom % NP);
      cfg_care   = 8'($urandom & $urandom);
      cfg_match  = 8'($urandom);
      cfg_target = 4'($urandom);
      cfg_en     = ($urandom % 4) != 0;
      cfg_commit = ($urandom % 8) == 0;
      hit_clr    = ($urandom % 8) == 0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
